// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and owner index width
//   arb_state_t   : arbiter FSM states
//   next_rr()     : round-robin winner search starting after 'last'
package arb8_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Scan last+1, last+2, ... wrapping 7->0; the 3-bit add does the wrap.
   // Returns 'last' when nothing is requested (caller gates on |req).
   function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] idx;
      logic             found;
      next_rr = last;
      found   = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = last + IDX_W'(i);
         if (!found && req[idx]) begin
            next_rr = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the arbiter.
//   req     : request vector, bit k = requester k (level)
//   gnt     : one-hot grant or zero
//   gnt_idx : binary owner index, meaningful while gnt_vld=1
//   gnt_vld : any grant active
//   tmo     : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
   import arb8_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_vld;
   logic             tmo;

   modport master (output req, input gnt, gnt_idx, gnt_vld, tmo);
   modport slave  (input req, output gnt, gnt_idx, gnt_vld, tmo);
endinterface

// File: rtl/rr_arbiter8_dec3to8_onehot.sv
// Combinational 3-bit index to 8-bit one-hot decoder.
//   idx    : binary index in
//   onehot : decoded one-hot out
module dec3to8_onehot
   import arb8_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// Optional feature macro: ARB8_TIMEOUT_EN (hold-time limit of MAX_HOLD cycles
// with forced release and tmo pulse). Without it tmo is tied low.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   arb : rr_arbiter8_if.slave (req in; gnt, gnt_idx, gnt_vld, tmo out)
//
// state    | meaning
// ARB_IDLE | no grant; arbitrate among req from last+1
// ARB_BUSY | owner holds the grant until its req drops (or times out)
module rr_arbiter8
   import arb8_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic         clk,
   input  logic         rst,
   rr_arbiter8_if.slave arb
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter8: MAX_HOLD must be within 1..255");
   end

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] last, last_nxt;
   logic [IDX_W-1:0] winner;
   logic [N_REQ-1:0] dec_out;
   logic [N_REQ-1:0] gnt_nxt;
   logic             vld_nxt;
   logic             tmo_nxt;
   logic             own_req;
   logic             timeout_hit;

   assign winner  = next_rr(arb.req, last);
   assign own_req = arb.req[owner];

`ifdef ARB8_TIMEOUT_EN
   logic [7:0] hold_cnt;

   assign timeout_hit = (state == ARB_BUSY) && own_req && (hold_cnt == 8'(MAX_HOLD - 1));

   // Zero in the first BUSY cycle, counts up while the grant is kept.
   always_ff @(posedge clk) begin
      if (rst)
         hold_cnt <= 8'd0;
      else if (state == ARB_BUSY && state_nxt == ARB_BUSY)
         hold_cnt <= hold_cnt + 8'd1;
      else
         hold_cnt <= 8'd0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      tmo_nxt   = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (|arb.req) begin
               owner_nxt = winner;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (!own_req || timeout_hit) begin
               last_nxt  = owner;
               state_nxt = ARB_IDLE;
               tmo_nxt   = timeout_hit;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Outputs are computed from next-state values so the registered grant
   // appears right after the arbitration edge.
   dec3to8_onehot u_dec (
      .idx    (owner_nxt),
      .onehot (dec_out)
   );

   always_comb begin
      vld_nxt = (state_nxt == ARB_BUSY);
      gnt_nxt = vld_nxt ? dec_out : '0;
   end

   // last resets to 7 so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner       <= '0;
         last        <= IDX_W'(N_REQ - 1);
         arb.gnt     <= '0;
         arb.gnt_idx <= '0;
         arb.gnt_vld <= 1'b0;
         arb.tmo     <= 1'b0;
      end else begin
         owner       <= owner_nxt;
         last        <= last_nxt;
         arb.gnt     <= gnt_nxt;
         arb.gnt_idx <= owner_nxt;
         arb.gnt_vld <= vld_nxt;
         arb.tmo     <= tmo_nxt;
      end
   end

endmodule
